// File: rtl/tank_match_ctrl.sv
// Match sequencer for the two-tank game: start/countdown/play/hit/game-over flow,
// hit edge detection, score keeping, movement gating and respawn pulses. One cycle = one frame.
module tank_match_ctrl #(
    parameter int         WIN_SCORE   = 3,
    parameter int         STEP_FRAMES = 60,
    parameter int         HIT_FRAMES  = 90,
    parameter logic [7:0] START_KEY   = 8'h28
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    input  logic       Bullet1_Tank2_intersect,
    input  logic       Bullet2_Tank1_intersect,
    output logic       Play_En,
    output logic       Respawn,
    output logic [3:0] Score1,
    output logic [3:0] Score2,
    output logic [1:0] Countdown,
    output logic [1:0] Winner,
    output logic [2:0] State
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_HIT   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN     = 4'(WIN_SCORE);
    localparam logic [7:0] STEP_M1 = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] HIT_M1  = 8'(HIT_FRAMES - 1);

    state_t     state, state_n;
    logic [7:0] timer, timer_n;
    logic [3:0] s1_n, s2_n;
    logic [1:0] cd_n, win_n;
    logic       resp_n;
    logic       start_d, i1_d, i2_d;
    logic       key_now, start, h1, h2;

    assign key_now = (keycode == START_KEY) || (keycode2 == START_KEY);
    assign start   = key_now & ~start_d;
    assign h1      = Bullet1_Tank2_intersect & ~i1_d;
    assign h2      = Bullet2_Tank1_intersect & ~i2_d;

    // Movement gate follows the state register, so it drops the cycle after a hit edge.
    assign Play_En = (state == S_PLAY);
    assign State   = state;

    always_comb begin
        state_n = state;
        timer_n = timer;
        cd_n    = Countdown;
        s1_n    = Score1;
        s2_n    = Score2;
        win_n   = Winner;
        resp_n  = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    s1_n    = 4'd0;
                    s2_n    = 4'd0;
                    win_n   = 2'd0;
                    resp_n  = 1'b1;
                    cd_n    = 2'd3;
                    timer_n = 8'd0;
                    state_n = S_COUNT;
                end
            end
            S_COUNT: begin
                if (timer == STEP_M1) begin
                    timer_n = 8'd0;
                    cd_n    = Countdown - 2'd1;
                    if (Countdown == 2'd1) state_n = S_PLAY;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            S_PLAY: begin
                // Simultaneous edges are a draw: freeze without scoring.
                if (h1 && !h2 && Score1 < WIN) s1_n = Score1 + 4'd1;
                if (h2 && !h1 && Score2 < WIN) s2_n = Score2 + 4'd1;
                if (h1 || h2) begin
                    timer_n = 8'd0;
                    state_n = S_HIT;
                end
            end
            S_HIT: begin
                if (timer == HIT_M1) begin
                    timer_n = 8'd0;
                    if (Score1 == WIN) begin
                        win_n   = 2'd1;
                        state_n = S_OVER;
                    end else if (Score2 == WIN) begin
                        win_n   = 2'd2;
                        state_n = S_OVER;
                    end else begin
                        resp_n  = 1'b1;
                        cd_n    = 2'd3;
                        state_n = S_COUNT;
                    end
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = 8'd0;
                cd_n    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            timer     <= 8'd0;
            Countdown <= 2'd0;
            Score1    <= 4'd0;
            Score2    <= 4'd0;
            Winner    <= 2'd0;
            Respawn   <= 1'b0;
            start_d   <= 1'b0;
            i1_d      <= 1'b0;
            i2_d      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            Countdown <= cd_n;
            Score1    <= s1_n;
            Score2    <= s2_n;
            Winner    <= win_n;
            Respawn   <= resp_n;
            start_d   <= key_now;
            i1_d      <= Bullet1_Tank2_intersect;
            i2_d      <= Bullet2_Tank1_intersect;
        end
    end
endmodule

// File: tb/tb_tank_match_ctrl.sv
// Directed bench for tank_match_ctrl with WIN_SCORE=2, STEP_FRAMES=4, HIT_FRAMES=3.
module tb_tank_match_ctrl;
    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00, keycode2 = 8'h00;
    logic       b1 = 1'b0, b2 = 1'b0;
    logic       Play_En, Respawn;
    logic [3:0] Score1, Score2;
    logic [1:0] Countdown, Winner;
    logic [2:0] State;
    int         checks = 0, errors = 0;

    tank_match_ctrl #(.WIN_SCORE(2), .STEP_FRAMES(4), .HIT_FRAMES(3), .START_KEY(8'h28)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode2(keycode2),
        .Bullet1_Tank2_intersect(b1), .Bullet2_Tank1_intersect(b2),
        .Play_En(Play_En), .Respawn(Respawn), .Score1(Score1), .Score2(Score2),
        .Countdown(Countdown), .Winner(Winner), .State(State)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset, held start key, countdown 3/2/1 over 12 frames
        ticks(2);
        chk("rst_state", 8'(State), 8'd0);
        chk("rst_play", 8'(Play_En), 8'd0);
        chk("rst_resp", 8'(Respawn), 8'd0);
        chk("rst_cd", 8'(Countdown), 8'd0);
        chk("rst_score", 8'({Score1, Score2}), 8'd0);
        Reset = 1'b0;
        keycode = 8'h28;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("cd_state", 8'(State), 8'd1);
            chk("cd_digit", 8'(Countdown), 8'(3 - (i - 1) / 4));
            chk("cd_resp", 8'(Respawn), 8'(i == 1));
            chk("cd_play", 8'(Play_En), 8'd0);
            if (i == 10) keycode = 8'h00;
        end
        tick();
        chk("play_state", 8'(State), 8'd2);
        chk("play_en", 8'(Play_En), 8'd1);
        chk("play_cd", 8'(Countdown), 8'd0);
        tick();
        chk("play_hold", 8'(State), 8'd2);

        // 2: P1 hit, intersect held 5 frames counts once
        b1 = 1'b1;
        tick();
        chk("h1_score1", 8'(Score1), 8'd1);
        chk("h1_state", 8'(State), 8'd3);
        chk("h1_play", 8'(Play_En), 8'd0);
        ticks(2);
        chk("h1_wait_resp", 8'(Respawn), 8'd0);
        chk("h1_wait_state", 8'(State), 8'd3);
        tick();
        chk("h1_resp", 8'(Respawn), 8'd1);
        chk("h1_cd_state", 8'(State), 8'd1);
        chk("h1_cd_digit", 8'(Countdown), 8'd3);
        tick();
        b1 = 1'b0;
        chk("h1_resp_once", 8'(Respawn), 8'd0);
        chk("h1_score_once", 8'(Score1), 8'd1);
        ticks(11);
        chk("h1_back_play", 8'(State), 8'd2);

        // 3: simultaneous hits are a draw
        b1 = 1'b1; b2 = 1'b1;
        tick();
        b1 = 1'b0; b2 = 1'b0;
        chk("draw_state", 8'(State), 8'd3);
        chk("draw_scores", 8'({Score1, Score2}), 8'h10);
        ticks(3);
        chk("draw_resp", 8'(Respawn), 8'd1);
        chk("draw_cd", 8'(State), 8'd1);
        ticks(12);
        chk("draw_play", 8'(State), 8'd2);

        // 4: two P2 hits end the match; keycode2 restarts
        b2 = 1'b1;
        tick();
        b2 = 1'b0;
        chk("p2a_score2", 8'(Score2), 8'd1);
        ticks(3);
        chk("p2a_resp", 8'(Respawn), 8'd1);
        ticks(12);
        chk("p2a_play", 8'(State), 8'd2);
        b2 = 1'b1;
        tick();
        b2 = 1'b0;
        chk("p2b_score2", 8'(Score2), 8'd2);
        ticks(3);
        chk("over_state", 8'(State), 8'd4);
        chk("over_winner", 8'(Winner), 8'd2);
        chk("over_resp", 8'(Respawn), 8'd0);
        chk("over_play", 8'(Play_En), 8'd0);
        ticks(2);
        chk("over_hold", 8'({Score1, Score2}), 8'h12);
        keycode2 = 8'h28;
        tick();
        keycode2 = 8'h00;
        chk("restart_state", 8'(State), 8'd1);
        chk("restart_resp", 8'(Respawn), 8'd1);
        chk("restart_scores", 8'({Score1, Score2}), 8'h00);
        chk("restart_winner", 8'(Winner), 8'd0);
        chk("restart_cd", 8'(Countdown), 8'd3);

        // 5: reset mid-HIT overrides the pending respawn
        ticks(12);
        chk("r5_play", 8'(State), 8'd2);
        b1 = 1'b1;
        tick();
        b1 = 1'b0;
        chk("r5_score1", 8'(Score1), 8'd1);
        ticks(2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("r5_state", 8'(State), 8'd0);
        chk("r5_scores", 8'({Score1, Score2}), 8'h00);
        chk("r5_play_en", 8'(Play_En), 8'd0);
        chk("r5_resp", 8'(Respawn), 8'd0);

        // 6: intersect held across HIT->COUNTDOWN->PLAY scores only once
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        chk("s6_start", 8'(State), 8'd1);
        ticks(12);
        b1 = 1'b1;
        tick();
        chk("s6_score1", 8'(Score1), 8'd1);
        ticks(15);
        chk("s6_play", 8'(State), 8'd2);
        keycode = 8'h28;
        ticks(2);
        keycode = 8'h00;
        chk("s6_held_state", 8'(State), 8'd2);
        chk("s6_held_score", 8'(Score1), 8'd1);
        b1 = 1'b0;
        tick();
        b1 = 1'b1;
        tick();
        chk("s6_new_edge", 8'(Score1), 8'd2);
        ticks(3);
        chk("s6_over", 8'(State), 8'd4);
        chk("s6_winner", 8'(Winner), 8'd1);
        b1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
